// File: rtl/vga_mode_sequencer.sv
// Debounced push button steps the VGA display mode, applied only at frame boundaries.
// Define VGA_MODE_AUTO_CYCLE_EN to add long-press toggled automatic mode cycling.
module vga_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 90000,
  parameter int LONG_CYCLES     = 650000,
  parameter int AUTO_FRAMES     = 120,
  parameter int NUM_MODES       = 14
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key1,
  input  logic       frame_start,
  output logic [3:0] vga_dis_mode,
  output logic       mode_changed,
  output logic       auto_on,
  output logic       led
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, LONG} state_t;

  localparam logic [19:0] CNT_MAX   = 20'(LONG_CYCLES);
  localparam logic [19:0] DEB_LAST  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  LAST_MODE = 4'(NUM_MODES - 1);

  logic        key_meta_reg;
  logic        key_s_reg;
  logic [19:0] press_cnt_reg;
  state_t      state_reg;
  state_t      state_next;
  logic        short_press;
  logic        auto_step;
  logic        do_step;
  logic        step_pending_reg;
  logic        mode_changed_reg;
  logic [3:0]  mode_reg;

  // Sync flops idle high so a key held through reset is seen as a fresh press.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      key_meta_reg <= 1'b1;
      key_s_reg    <= 1'b1;
    end else begin
      key_meta_reg <= key1;
      key_s_reg    <= key_meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || key_s_reg) begin
      press_cnt_reg <= '0;
    end else if (press_cnt_reg != CNT_MAX) begin
      press_cnt_reg <= press_cnt_reg + 20'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

`ifdef VGA_MODE_AUTO_CYCLE_EN
  localparam logic [19:0] LONG_LAST  = 20'(LONG_CYCLES - 1);
  localparam logic [7:0]  FRAME_LAST = 8'(AUTO_FRAMES - 1);

  logic       long_press;
  logic       auto_on_reg;
  logic [7:0] frame_cnt_reg;
`endif

  always_comb begin
    state_next  = state_reg;
    short_press = 1'b0;
`ifdef VGA_MODE_AUTO_CYCLE_EN
    long_press  = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (!key_s_reg) state_next = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (key_s_reg) state_next = IDLE;
        else if (press_cnt_reg == DEB_LAST) state_next = HELD;
      end
      HELD: begin
        if (key_s_reg) begin
          state_next  = IDLE;
          short_press = 1'b1;
        end
`ifdef VGA_MODE_AUTO_CYCLE_EN
        else if (press_cnt_reg == LONG_LAST) begin
          state_next = LONG;
          long_press = 1'b1;
        end
`endif
      end
`ifdef VGA_MODE_AUTO_CYCLE_EN
      LONG: begin
        if (key_s_reg) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

`ifdef VGA_MODE_AUTO_CYCLE_EN
  assign auto_step = frame_start && auto_on_reg && (frame_cnt_reg == FRAME_LAST);

  // Any applied step restarts the auto interval, so a manual step is never followed early.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      auto_on_reg   <= 1'b0;
      frame_cnt_reg <= '0;
    end else if (long_press) begin
      auto_on_reg   <= ~auto_on_reg;
      frame_cnt_reg <= '0;
    end else if (do_step) begin
      frame_cnt_reg <= '0;
    end else if (frame_start && auto_on_reg) begin
      frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end
  end

  assign auto_on = auto_on_reg;
`else
  assign auto_step = 1'b0;
  assign auto_on   = 1'b0;
`endif

  assign do_step = frame_start && (step_pending_reg || auto_step);

  // A press landing on a frame_start cycle wins over the clear and waits for the next frame.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode_reg         <= '0;
      mode_changed_reg <= 1'b0;
      step_pending_reg <= 1'b0;
    end else begin
      mode_changed_reg <= do_step;
      if (do_step) begin
        mode_reg <= (mode_reg == LAST_MODE) ? 4'd0 : mode_reg + 4'd1;
      end
      if (short_press) begin
        step_pending_reg <= 1'b1;
      end else if (do_step) begin
        step_pending_reg <= 1'b0;
      end
    end
  end

  assign vga_dis_mode = mode_reg;
  assign mode_changed = mode_changed_reg;
  assign led          = (state_reg == HELD) || (state_reg == LONG);

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Randomised plus directed bench for vga_mode_sequencer, scored against a run-length model.
// Auto-cycle expectations follow VGA_MODE_AUTO_CYCLE_EN as defined for the build.
module tb_vga_mode_sequencer;

  localparam int D  = 4;
  localparam int LC = 20;
  localparam int AF = 3;
  localparam int NM = 14;
`ifdef VGA_MODE_AUTO_CYCLE_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       key1 = 1'b1;
  logic       frame_start = 1'b0;
  logic [3:0] vga_dis_mode;
  logic       mode_changed;
  logic       auto_on;
  logic       led;

  vga_mode_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(LC),
    .AUTO_FRAMES(AF),
    .NUM_MODES(NM)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .key1(key1),
    .frame_start(frame_start),
    .vga_dis_mode(vga_dis_mode),
    .mode_changed(mode_changed),
    .auto_on(auto_on),
    .led(led)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int mode;
    bit mc;
    bit led;
    bit auto_on;
  } exp_t;

  exp_t status_q[$];
  int   mode_q[$];
  int   errors = 0;
  int   checks = 0;
  int   led_seen = 0;

  // Reference model: behaviour follows from how long the synchronised key has been low.
  bit m_s1 = 1'b1, m_s2 = 1'b1;
  int m_run = 0;
  bit m_pending = 1'b0;
  bit m_auto = 1'b0;
  int m_fcnt = 0;
  int m_mode = 0;
  bit m_mc = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_advance(input bit k, input bit f, input bit r);
    bit key_s, press, toggle, auto_hit, step;
    if (!r) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_run = 0; m_pending = 1'b0;
      m_auto = 1'b0; m_fcnt = 0; m_mode = 0; m_mc = 1'b0;
      return;
    end
    key_s    = m_s2;
    press    = key_s && (m_run >= D) && (!AUTO_EN || m_run <= LC - 1);
    toggle   = AUTO_EN && !key_s && (m_run == LC - 1);
    auto_hit = AUTO_EN && f && m_auto && (m_fcnt == AF - 1);
    step     = f && (m_pending || auto_hit);
    m_mc     = step;
    if (step) begin
      m_mode = (m_mode + 1) % NM;
      mode_q.push_back(m_mode);
    end
    m_pending = (m_pending && !step) || press;
    if (toggle || step) m_fcnt = 0;
    else if (f && m_auto) m_fcnt = m_fcnt + 1;
    if (toggle) m_auto = !m_auto;
    m_run = key_s ? 0 : m_run + 1;
    m_s2 = m_s1;
    m_s1 = k;
  endtask

  task automatic tick(input bit k, input bit f, input bit r);
    exp_t e;
    key1 = k;
    frame_start = f;
    rstn = r;
    @(posedge clk);
    #1;
    model_advance(k, f, r);
    e.mode = m_mode;
    e.mc = m_mc;
    e.led = (m_run >= D);
    e.auto_on = m_auto;
    status_q.push_back(e);
    key1 = 1'b1;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'b0, 1'b1);
  endtask

  task automatic press(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic frame();
    tick(1'b1, 1'b1, 1'b1);
  endtask

  // Monitor: every cycle compares the DUT against the expected status; mode_changed pops a step.
  always @(negedge clk) begin
    exp_t e;
    int m;
    if (status_q.size() > 0) begin
      e = status_q.pop_front();
      check("mode", 32'(vga_dis_mode), 32'(e.mode));
      check("mode_changed", 32'(mode_changed), 32'(e.mc));
      check("led", 32'(led), 32'(e.led));
      check("auto_on", 32'(auto_on), 32'(e.auto_on));
      if (led === 1'b1) led_seen++;
      if (mode_changed === 1'b1) begin
        if (mode_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL step_queue: unexpected step, got mode %0d expected no step", vga_dis_mode);
        end else begin
          m = mode_q.pop_front();
          check("step_mode", 32'(vga_dis_mode), 32'(m));
          $display("step: mode -> %0d (expected %0d) auto_on=%0b at %0t", vga_dis_mode, m, auto_on, $time);
        end
      end
    end
  end

  initial begin
    int lo, hi, seen_before;
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    idle(4);

    $display("test: 10-cycle press then frame_start");
    press(10); idle(5); frame(); idle(5);

    $display("test: 2-cycle glitch then frame_start");
    @(negedge clk); #1;
    seen_before = led_seen;
    press(2); idle(5); frame(); idle(5);
    @(negedge clk); #1;
    check("glitch_led_never_high", 32'(led_seen - seen_before), 32'd0);

    $display("test: three short presses then one frame_start");
    repeat (3) begin press(8); idle(4); end
    frame(); idle(4);

    $display("test: 30-cycle press then 6 frame_start pulses");
    press(30); idle(4);
    repeat (6) begin frame(); idle(5); end
    press(30); idle(4);

    $display("test: walk mode to last value and wrap");
    for (int i = 0; i < 20 && m_mode != NM - 1; i++) begin
      press(8); idle(3); frame(); idle(3);
    end
    check("reached_last_mode", 32'(m_mode), 32'(NM - 1));
    press(8); idle(3); frame(); idle(3);

    $display("test: reset asserted mid-press");
    press(10);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    press(2); idle(5); frame(); idle(5);

    $display("test: randomised presses and frames");
    for (int i = 0; i < 250; i++) begin
      lo = $urandom_range(1, 32);
      hi = $urandom_range(1, 8);
      for (int c = 0; c < lo; c++) tick(1'b0, ($urandom_range(0, 5) == 0), 1'b1);
      for (int c = 0; c < hi; c++) tick(1'b1, ($urandom_range(0, 5) == 0), 1'b1);
    end
    idle(4); frame(); idle(4);

    @(negedge clk); #1;
    check("steps_outstanding", 32'(mode_q.size()), 32'd0);
    check("status_outstanding", 32'(status_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
